// File: rtl/rotor0_inv.sv
// rtl/rotor0_inv.sv - inverse rotor0 letter stage with stepping position register
//
// Purpose:
//   Maps a letter code arriving from the reflector side back toward the entry
//   side through the inverse of the fixed rotor0 wiring, offset by the current
//   rotor position:
//     data_out = (inv[data_in] + 26 - position) mod 26
//   The result is registered with a one-deep valid/ready output stage, so a
//   transfer completes with one cycle of latency. The position register loads
//   or steps independently of the data handshake.
//
// Ports:
//   clk             rising-edge clock for all state
//   rst             synchronous, active-high reset
//   data_in[4:0]    letter code from the reflector side (0-25)
//   in_valid        data_in is presented this cycle
//   in_ready        block accepts data_in this cycle (combinational)
//   set_up[4:0]     start position, taken when load=1
//   load            load set_up (mod 26) into the position register
//   rotate_carryin  step request, advances position by one
//   data_out[4:0]   letter code toward the entry side
//   out_valid       data_out holds a result
//   out_ready       consumer takes data_out this cycle
//   rotate_carry    one-cycle pulse after position wraps 25 -> 0
//   position[4:0]   current rotor position (0-25)
//   err             one-cycle range-error pulse, aligned with out_valid
//
// Configuration:
//   ROTOR0_INV_RANGE_CHECK_EN  defined: a transferred data_in of 26-31 yields
//                              data_out=31 and an err pulse.
//                              undefined: data_in 26-31 folds to data_in-26
//                              and err is tied low.

module rotor0_inv (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] set_up,
  input  logic       load,
  input  logic       rotate_carryin,
  output logic [4:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rotate_carry,
  output logic [4:0] position,
  output logic       err
);

  // Inverse of the rotor0 wiring: inv[map[i]] == i.
  function automatic logic [4:0] inv_map(input logic [4:0] idx);
    logic [4:0] v;
    case (idx)
      5'd0:    v = 5'd20;
      5'd1:    v = 5'd22;
      5'd2:    v = 5'd24;
      5'd3:    v = 5'd6;
      5'd4:    v = 5'd0;
      5'd5:    v = 5'd3;
      5'd6:    v = 5'd5;
      5'd7:    v = 5'd15;
      5'd8:    v = 5'd21;
      5'd9:    v = 5'd25;
      5'd10:   v = 5'd1;
      5'd11:   v = 5'd4;
      5'd12:   v = 5'd2;
      5'd13:   v = 5'd10;
      5'd14:   v = 5'd12;
      5'd15:   v = 5'd19;
      5'd16:   v = 5'd7;
      5'd17:   v = 5'd23;
      5'd18:   v = 5'd18;
      5'd19:   v = 5'd11;
      5'd20:   v = 5'd17;
      5'd21:   v = 5'd8;
      5'd22:   v = 5'd13;
      5'd23:   v = 5'd16;
      5'd24:   v = 5'd14;
      5'd25:   v = 5'd9;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

  logic       xfer;
  logic [4:0] idx;
  logic [4:0] inv_val;
  logic [4:0] shifted;
  logic [4:0] result;
  logic       bad_in;
  logic [4:0] load_pos;

  // Output stage frees up when empty or when the consumer drains it this cycle.
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    idx      = 5'd0;
    inv_val  = 5'd0;
    shifted  = 5'd0;
    result   = 5'd0;
    bad_in   = 1'b0;
    load_pos = 5'd0;

    idx     = (data_in >= 5'd26) ? (data_in - 5'd26) : data_in;
    inv_val = inv_map(idx);

    // Subtract position modulo 26. When inv_val < position the true value
    // inv_val + 26 - position exceeds nothing below 26, but the intermediate
    // sum may pass 31; 5-bit wrap arithmetic keeps the final value exact.
    if (inv_val >= position) begin
      shifted = inv_val - position;
    end else begin
      shifted = inv_val + 5'd26 - position;
    end

`ifdef ROTOR0_INV_RANGE_CHECK_EN
    bad_in = (data_in >= 5'd26);
    result = bad_in ? 5'd31 : shifted;
`else
    bad_in = 1'b0;
    result = shifted;
`endif

    load_pos = (set_up >= 5'd26) ? (set_up - 5'd26) : set_up;
  end

  // Output stage: a transfer always overwrites; otherwise a drain clears
  // valid and a stall holds both data_out and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= 5'd0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      data_out  <= result;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Position register. The translation above reads the pre-edge position,
  // so a load or step on the same edge only affects later transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      position     <= 5'd0;
      rotate_carry <= 1'b0;
    end else if (load) begin
      position     <= load_pos;
      rotate_carry <= 1'b0;
    end else if (rotate_carryin) begin
      if (position >= 5'd25) begin
        position     <= 5'd0;
        rotate_carry <= 1'b1;
      end else begin
        position     <= position + 5'd1;
        rotate_carry <= 1'b0;
      end
    end else begin
      rotate_carry <= 1'b0;
    end
  end

`ifdef ROTOR0_INV_RANGE_CHECK_EN
  logic err_q;

  // Pulses for the single cycle in which the bad result first appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= xfer && bad_in;
    end
  end

  assign err = err_q;
`else
  logic unused_bad;
  assign unused_bad = bad_in;
  assign err        = 1'b0;
`endif

endmodule
